// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage. It issues data-memory requests, stalls the pipe until the memory
// acks, raises a sticky error on timeout, and registers the write-back slot.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_WriteData,
  input  logic [3:0]  MEM_rd,
  input  logic        MEM_RegWrite,
  input  logic        MEM_MemToReg,
  input  logic        MEM_MemWrite,
  input  logic        MEM_valid,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        mem_error,
  output logic [31:0] WB_Result,
  output logic [3:0]  WB_rd,
  output logic        WB_RegWrite,
  output logic        WB_valid
);

  typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic        mem_error_q, mem_error_d;
  logic        mem_op, req_wait;
  logic [31:0] wb_result_q;
  logic [3:0]  wb_rd_q;
  logic        wb_regwrite_q, wb_valid_q;

  assign mem_op     = MEM_valid & (MEM_MemToReg | MEM_MemWrite);
  assign dmem_req   = mem_op & (state_q != StErr);
  assign dmem_we    = MEM_MemWrite;
  assign dmem_addr  = MEM_ALUResult;
  assign dmem_wdata = MEM_WriteData;
  assign req_wait   = dmem_req & ~dmem_ack;
  assign stall      = req_wait | (state_q == StErr);
  assign cnt_inc    = cnt_q + 8'd1;

  assign mem_error   = mem_error_q;
  assign WB_Result   = wb_result_q;
  assign WB_rd       = wb_rd_q;
  assign WB_RegWrite = wb_regwrite_q;
  assign WB_valid    = wb_valid_q;

  // An ack always wins over a timeout in the same cycle because req_wait is then low.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_error_d = mem_error_q;
    if (state_q != StErr) begin
      if (req_wait) begin
        cnt_d = cnt_inc;
        if (cnt_inc == TimeoutCnt) begin
          state_d     = StErr;
          mem_error_d = 1'b1;
        end else begin
          state_d = StWait;
        end
      end else begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  // A stall inserts a bubble; result and rd keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_result_q   <= 32'd0;
      wb_rd_q       <= 4'd0;
      wb_regwrite_q <= 1'b0;
      wb_valid_q    <= 1'b0;
    end else if (stall) begin
      wb_regwrite_q <= 1'b0;
      wb_valid_q    <= 1'b0;
    end else begin
      wb_result_q   <= MEM_MemToReg ? dmem_rdata : MEM_ALUResult;
      wb_rd_q       <= MEM_rd;
      wb_regwrite_q <= MEM_RegWrite & MEM_valid;
      wb_valid_q    <= MEM_valid;
    end
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 15, consecutive un-acked request cycles before error (legal 1..255).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- MEM_ALUResult  in  32  address or ALU result from the EX/MEM register.
- MEM_WriteData  in  32  store data.
- MEM_rd  in  4  destination register.
- MEM_RegWrite  in  1  register-write control.
- MEM_MemToReg  in  1  load control.
- MEM_MemWrite  in  1  store control.
- MEM_valid  in  1  instruction present.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  address.
- dmem_wdata  out  32  write data.
- dmem_rdata  in  32  read data, valid with dmem_ack.
- dmem_ack  in  1  access complete this cycle.
- stall  out  1  hold upstream stages.
- mem_error  out  1  sticky timeout flag.
- WB_Result  out  32  write-back data.
- WB_rd  out  4  write-back register.
- WB_RegWrite  out  1  write-back enable.
- WB_valid  out  1  WB slot holds an instruction.

Function
REQ-003 SHALL classify mem_op = MEM_valid & (MEM_MemToReg | MEM_MemWrite).
REQ-004 SHALL drive dmem_req = mem_op & (state != ERR), combinationally.
REQ-005 SHALL drive dmem_we = MEM_MemWrite, dmem_addr = MEM_ALUResult, and dmem_wdata = MEM_WriteData, combinationally.
REQ-006 SHALL drive stall = (dmem_req & ~dmem_ack) | (state == ERR).
REQ-007 SHALL implement FSM states IDLE, WAIT, ERR.
- IDLE -> WAIT on dmem_req & ~dmem_ack.
- WAIT -> IDLE on dmem_ack.
- IDLE/WAIT -> ERR when the wait count reaches TIMEOUT.
- ERR is terminal until reset.
REQ-008 SHALL keep an 8-bit wait counter:
- Increment on each dmem_req & ~dmem_ack cycle.
- Clear to 0 on ack, or on any cycle without a request.
- Enter ERR on the edge where the incremented value equals TIMEOUT.
REQ-009 SHALL register mem_error = 1 on entry to ERR, and hold it until reset.
REQ-010 SHALL load the WB register on every rising edge when stall = 0:
- WB_valid <= MEM_valid.
- WB_rd <= MEM_rd.
- WB_RegWrite <= MEM_RegWrite & MEM_valid.
- WB_Result <= dmem_rdata if MEM_MemToReg, else MEM_ALUResult.
REQ-011 SHALL insert a bubble on every edge with stall = 1: WB_valid <= 0 and WB_RegWrite <= 0; WB_Result and WB_rd hold.
REQ-012 SHALL give 1-cycle latency for non-memory ops, and 1 + (ack wait cycles) for memory ops.
REQ-013 SHALL rely on upstream holding all MEM_* inputs stable while stall = 1; dmem request fields therefore stay stable until ack.
REQ-014 SHALL treat a store as a single access: on ack, WB_RegWrite follows MEM_RegWrite (normally 0).
REQ-015 SHALL treat ack with dmem_req = 0 as ignored, with no state change.
REQ-016 SHALL, when dmem_ack arrives in the same cycle the counter would reach TIMEOUT, let ack win: the instruction completes and the FSM returns to IDLE.
REQ-017 SHALL treat MEM_valid = 0 as a bubble: no request, no stall, WB_valid <= 0.

Reset
REQ-018 SHALL, while rst_n = 0, asynchronously force:
- WB_Result = 0, WB_rd = 0, WB_RegWrite = 0, WB_valid = 0.
- mem_error = 0, state = IDLE, counter = 0.
REQ-019 SHALL, on reset mid-WAIT, abandon the access; dmem_req then reflects only the current inputs after release.
REQ-020 SHALL make the first post-reset edge with rst_n = 1 behave as a normal IDLE edge.

Verification
REQ-021 ALU op: MEM_valid = 1, ALUResult = 0x00001234, rd = 5, RegWrite = 1 -> next edge WB_Result = 0x00001234, WB_rd = 5, WB_RegWrite = 1, WB_valid = 1; stall never 1.
REQ-022 Zero-wait load: MemToReg = 1, addr = 0x40, dmem_ack = 1 same cycle with rdata = 0xDEADBEEF -> dmem_req = 1, stall = 0, next edge WB_Result = 0xDEADBEEF.
REQ-023 Waited load: ack on the 4th request cycle -> stall = 1 for 3 cycles, WB_valid = 0 on those edges, WB_Result = rdata on the ack edge, then FSM in IDLE.
REQ-024 Store: MemWrite = 1, addr = 0x80, WriteData = 0xCAFEF00D, RegWrite = 0, ack after 1 wait -> dmem_we = 1 with stable addr/wdata, WB_RegWrite = 0, WB_valid = 1 after ack.
REQ-025 Timeout with TIMEOUT = 4 and no ack: mem_error = 1 after the 4th request edge, dmem_req = 0 and stall = 1 thereafter; rst_n low clears all. Repeat with ack on the 4th cycle -> completes, mem_error stays 0.
REQ-026 Reset mid-WAIT: rst_n low 2 cycles into a wait -> WB outputs 0 immediately without a clock edge; after release, an ALU op passes with 1-cycle latency.
